// File: rtl/gpio_checker.sv
// gpio_checker: table-driven gpio sequence checker (exact-cycle or wait-for-match)
module gpio_checker #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 4,
  parameter int DELAY_WIDTH = 8,
  parameter int MODE        = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  gpio,
  input  logic                   wr_en,
  input  logic [DEPTH_LOG2-1:0]  wr_addr,
  input  logic [DELAY_WIDTH-1:0] wr_delay,
  input  logic [DATA_WIDTH-1:0]  wr_value,
  input  logic [DATA_WIDTH-1:0]  wr_mask,
  input  logic [DEPTH_LOG2:0]    count,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [DEPTH_LOG2-1:0]  fail_idx,
  output logic [DATA_WIDTH-1:0]  fail_actual,
  output logic [DATA_WIDTH-1:0]  fail_expected
);
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  logic [DELAY_WIDTH-1:0] delay_mem [DEPTH];
  logic [DATA_WIDTH-1:0]  value_mem [DEPTH];
  logic [DATA_WIDTH-1:0]  mask_mem  [DEPTH];
  state_t                 state_q, state_d;
  logic [DEPTH_LOG2:0]    cnt_q, cnt_d, idx_q, idx_d, idx_n, cnt_sat;
  logic [DELAY_WIDTH-1:0] timer_q, timer_d;
  logic [DEPTH_LOG2-1:0]  fail_idx_q, fail_idx_d, ia;
  logic [DATA_WIDTH-1:0]  fail_actual_q, fail_actual_d, fail_expected_q, fail_expected_d;
  logic                   hit, cmp;
  always_ff @(posedge clk)
    if (wr_en && state_q != RUN) begin
      delay_mem[wr_addr] <= wr_delay;
      value_mem[wr_addr] <= wr_value;
      mask_mem[wr_addr]  <= wr_mask;
    end
  assign ia      = idx_q[DEPTH_LOG2-1:0];
  assign idx_n   = idx_q + 1'b1;
  assign hit     = ((gpio ^ value_mem[ia]) & mask_mem[ia]) == '0;
  assign cmp     = (MODE == 0) ? (timer_q == '0) : 1'b1;
  assign cnt_sat = (count > FULL) ? FULL : count;
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    timer_d         = timer_q;
    fail_idx_d      = fail_idx_q;
    fail_actual_d   = fail_actual_q;
    fail_expected_d = fail_expected_q;
    if (abort) begin
      state_d         = IDLE;
      fail_idx_d      = '0;
      fail_actual_d   = '0;
      fail_expected_d = '0;
    end else if (state_q == RUN) begin
      if (cmp && hit) begin
        idx_d   = idx_n;
        timer_d = delay_mem[idx_n[DEPTH_LOG2-1:0]];
        state_d = (idx_n == cnt_q) ? PASS : RUN;
      end else if (timer_q == '0) begin
        state_d         = FAIL;
        fail_idx_d      = ia;
        fail_actual_d   = gpio;
        fail_expected_d = value_mem[ia];
      end else
        timer_d = timer_q - 1'b1;
    end else if (start) begin
      cnt_d           = cnt_sat;
      idx_d           = '0;
      timer_d         = delay_mem[0];
      fail_idx_d      = '0;
      fail_actual_d   = '0;
      fail_expected_d = '0;
      state_d         = (cnt_sat == '0) ? PASS : RUN;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      timer_q         <= '0;
      fail_idx_q      <= '0;
      fail_actual_q   <= '0;
      fail_expected_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      timer_q         <= timer_d;
      fail_idx_q      <= fail_idx_d;
      fail_actual_q   <= fail_actual_d;
      fail_expected_q <= fail_expected_d;
    end
  assign busy          = state_q == RUN;
  assign done          = state_q == PASS || state_q == FAIL;
  assign pass          = state_q == PASS;
  assign fail_idx      = fail_idx_q;
  assign fail_actual   = fail_actual_q;
  assign fail_expected = fail_expected_q;
endmodule

// File: doc/gpio_checker.md
GPIO_CHECKER -- requirements
Module: gpio_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the monitored gpio bus and expected/mask values.
REQ-002 Parameter DEPTH_LOG2, default 4, expectation table holds 2**DEPTH_LOG2 entries.
REQ-003 Parameter DELAY_WIDTH, default 8, width of the per-entry delay/timeout field.
REQ-004 Parameter MODE, default 0, where 0 = exact-cycle check and 1 = wait-for-match with timeout.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 gpio  input  DATA_WIDTH  bus under test, sampled on every rising edge.
REQ-008 wr_en  input  1  table write strobe.
REQ-009 wr_addr  input  DEPTH_LOG2  table entry index.
REQ-010 wr_delay  input  DELAY_WIDTH  cycles before the check (MODE 0) or timeout (MODE 1).
REQ-011 wr_value  input  DATA_WIDTH  expected value.
REQ-012 wr_mask  input  DATA_WIDTH  compare mask; 1 = bit checked.
REQ-013 count  input  DEPTH_LOG2+1  number of entries to run, sampled with start.
REQ-014 start  input  1  begin a run.
REQ-015 abort  input  1  cancel a run.
REQ-016 busy  output  1  run in progress.
REQ-017 done  output  1  run finished, sticky.
REQ-018 pass  output  1  all entries matched, valid when done=1.
REQ-019 fail_idx  output  DEPTH_LOG2  index of the failing entry.
REQ-020 fail_actual  output  DATA_WIDTH  gpio value captured at failure.
REQ-021 fail_expected  output  DATA_WIDTH  expected value of the failing entry.

Function
REQ-022 The block SHALL use states IDLE, RUN, PASS and FAIL.
REQ-023 A write with wr_en=1 SHALL update entry wr_addr only in IDLE, PASS or FAIL; writes in RUN SHALL be ignored.
REQ-024 On start=1 in IDLE, PASS or FAIL, the block SHALL latch count, clear done, pass and the fail_* outputs, set idx=0, and load the timer with delay[0].
- count=0: go to PASS next cycle.
- count>2**DEPTH_LOG2: saturate to 2**DEPTH_LOG2.
REQ-025 In RUN, start SHALL be ignored.
REQ-026 A match SHALL mean (gpio & mask[idx]) == (value[idx] & mask[idx]).
REQ-027 MODE 0, RUN, timer nonzero: decrement the timer and perform no compare.
REQ-028 MODE 0, RUN, timer zero: compare the entry.
- On match: advance idx and load delay[idx+1].
- On mismatch: go to FAIL.
- Timing: the first compare occurs delay[0]+1 cycles after the start edge; each later compare occurs delay[i]+1 cycles after the previous compare.
REQ-029 MODE 1, RUN: compare every cycle.
- On match: advance idx immediately and load the next delay.
- On mismatch with timer zero: go to FAIL.
- Otherwise: decrement the timer.
REQ-030 A match on the last entry (idx = count-1) SHALL enter PASS on the next edge.
REQ-031 On entering FAIL, fail_idx, fail_actual and fail_expected SHALL be captured from the comparing cycle.
REQ-032 Outputs by state:
- busy = 1 exactly in RUN.
- done = 1 in PASS and FAIL.
- pass = 1 only in PASS.
REQ-033 PASS and FAIL SHALL hold until start, abort or reset.
REQ-034 abort=1 in any state SHALL return to IDLE with done=0 and pass=0; abort SHALL take priority over start and over a compare in the same cycle.
REQ-035 The timer SHALL be DELAY_WIDTH bits and SHALL never wrap below zero.
REQ-036 Idx arithmetic SHALL be DEPTH_LOG2+1 bits so that a full-depth run terminates without aliasing.

Reset
REQ-037 reset=1 SHALL force IDLE and drive busy, done, pass, fail_idx, fail_actual and fail_expected to 0 on the next edge, including mid-run.
REQ-038 reset SHALL override abort and start.
REQ-039 Table contents SHALL NOT be cleared by reset.

Verification
REQ-040 MODE 0: 3 entries with delay 13, 0, 0, values FFFFFFFF, 1, 6, mask all ones; gpio driven accordingly -> done=1, pass=1, busy low one cycle after the third compare.
REQ-041 MODE 0: same table with gpio=5 instead of 6 at the third compare -> FAIL, fail_idx=2, fail_actual=5, fail_expected=6.
REQ-042 MODE 1: entry delay=4, value 700A; gpio reaches 700A on the 3rd cycle -> advance and pass; separate run with gpio never matching -> FAIL exactly 5 cycles after start.
REQ-043 Mask 000000FF with value FFFFFF00 against gpio 12345600 -> match; count=0 -> pass=1 one cycle after start.
REQ-044 Reset asserted mid-run, then abort mid-run, then a write in RUN -> outputs 0 and state IDLE each time; the write has no effect, confirmed by a rerun.
REQ-045 Back-to-back runs: start asserted in PASS -> done clears next cycle and the new run uses the newly latched count.
